// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the register file with
//                write-to-read bypass and pending-write scoreboard.
//                Holds the default data/index widths and the register index
//                type used by decode logic at the default configuration.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_ADDR_WIDTH = 5;

    typedef logic [c_DEF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Port bundle between the decode/writeback stages and the
//                register file.
//                master : decode/writeback side (drives write, read indices,
//                         issue request; receives read data, hazards, stall)
//                slave  : register file side
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
);

    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  hazard_A;
    logic                  hazard_B;
    logic                  ctrl_issueValid;
    logic [ADDR_WIDTH-1:0] ctrl_issueReg;
    logic                  issue_stall;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB,
        output ctrl_issueValid, ctrl_issueReg,
        input  data_readRegA, data_readRegB,
        input  hazard_A, hazard_B, issue_stall
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB,
        input  ctrl_issueValid, ctrl_issueReg,
        output data_readRegA, data_readRegB,
        output hazard_A, hazard_B, issue_stall
    );

endinterface : regfile_scoreboard_if
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register pending-write scoreboard.
//                A register becomes pending when decode issues an instruction
//                targeting it and is cleared by its writeback. Reports RAW
//                hazards on the two read ports and stalls WAW issues.
//  Ports       : clk, rst              clock, synchronous active-high reset
//                i_wr_en, i_wr_idx     writeback strobe / destination
//                i_rd_idx_a/b          read port indices
//                i_issue_valid/idx     issue request / destination
//                o_hazard_a/b          read source awaiting a write
//                o_issue_stall         issue refused this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_idx,
    input  wire logic [ADDR_WIDTH-1:0] i_rd_idx_a,
    input  wire logic [ADDR_WIDTH-1:0] i_rd_idx_b,
    input  wire logic                  i_issue_valid,
    input  wire logic [ADDR_WIDTH-1:0] i_issue_idx,
    output logic                       o_hazard_a,
    output logic                       o_hazard_b,
    output logic                       o_issue_stall
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [c_DEPTH-1:0] r_pending;
    logic [c_DEPTH-1:0] w_pending_nxt;
    logic               w_wr_live;
    logic               w_hit_a;
    logic               w_hit_b;
    logic               w_hit_issue;
    logic               w_stall;
    logic               w_accept;

    // A writeback in progress already satisfies its register this cycle,
    // so it masks the pending bit before the edge clears it.
    assign w_wr_live   = i_wr_en && (i_wr_idx != '0);
    assign w_hit_a     = i_wr_en && (i_wr_idx == i_rd_idx_a);
    assign w_hit_b     = i_wr_en && (i_wr_idx == i_rd_idx_b);
    assign w_hit_issue = i_wr_en && (i_wr_idx == i_issue_idx);

    // pending[0] is never set, so index 0 never hazards or stalls.
    assign o_hazard_a = r_pending[i_rd_idx_a] && !w_hit_a;
    assign o_hazard_b = r_pending[i_rd_idx_b] && !w_hit_b;

    assign w_stall = i_issue_valid && (i_issue_idx != '0) &&
                     r_pending[i_issue_idx] && !w_hit_issue;
    assign w_accept = i_issue_valid && !w_stall && (i_issue_idx != '0);
    assign o_issue_stall = w_stall;

    // Clear first, then set: a same-register accepted issue overrides the
    // writeback so the new producer remains outstanding.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_live) begin
            w_pending_nxt[i_wr_idx] = 1'b0;
        end
        if (w_accept) begin
            w_pending_nxt[i_issue_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Parametrised register file (2**ADDR_WIDTH x DATA_WIDTH)
//                with register 0 hardwired to zero, same-cycle write-to-read
//                bypass on both read ports, and a pending-write scoreboard.
//  Ports       : clock       rising-edge clock
//                ctrl_reset  synchronous active-high reset
//                bus         regfile_scoreboard_if.slave: writeback, two read
//                            ports with hazard flags, issue request / stall
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  wire logic            clock,
    input  wire logic            ctrl_reset,
    regfile_scoreboard_if.slave  bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_hazard_a;
    logic                  w_hazard_b;
    logic                  w_issue_stall;

    // Entry 0 is never written, so it holds its reset value of zero; the
    // read muxes also force zero for index 0 independently of storage.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0)) begin
            r_mem[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    always_comb begin
        w_rd_a = r_mem[bus.ctrl_readRegA];
        if (bus.ctrl_readRegA == '0) begin
            w_rd_a = '0;
        end else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegA)) begin
            w_rd_a = bus.data_writeReg;
        end
    end

    always_comb begin
        w_rd_b = r_mem[bus.ctrl_readRegB];
        if (bus.ctrl_readRegB == '0) begin
            w_rd_b = '0;
        end else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == bus.ctrl_readRegB)) begin
            w_rd_b = bus.data_writeReg;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk           (clock),
        .rst           (ctrl_reset),
        .i_wr_en       (bus.ctrl_writeEnable),
        .i_wr_idx      (bus.ctrl_writeReg),
        .i_rd_idx_a    (bus.ctrl_readRegA),
        .i_rd_idx_b    (bus.ctrl_readRegB),
        .i_issue_valid (bus.ctrl_issueValid),
        .i_issue_idx   (bus.ctrl_issueReg),
        .o_hazard_a    (w_hazard_a),
        .o_hazard_b    (w_hazard_b),
        .o_issue_stall (w_issue_stall)
    );

    assign bus.data_readRegA = w_rd_a;
    assign bus.data_readRegB = w_rd_b;
    assign bus.hazard_A      = w_hazard_a;
    assign bus.hazard_B      = w_hazard_b;
    assign bus.issue_stall   = w_issue_stall;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench for regfile_scoreboard. A default
//                32x32 instance runs directed scenarios and random traffic
//                against an array/flag reference model; a 16-bit, 8-entry
//                instance covers the narrow configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic clk;
    logic rst;
    logic rst_s;

    int n_tests;
    int n_fail;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    regfile_scoreboard_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) sb ();

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_dut (
        .clock      (clk),
        .ctrl_reset (rst),
        .bus        (bus)
    );

    regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_dut_s (
        .clock      (clk),
        .ctrl_reset (rst_s),
        .bus        (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents and outstanding
    // producers, one entry per register.
    logic [31:0] m_mem  [32];
    bit          m_pend [32];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit we, input int wr, input logic [31:0] wd,
                         input int ra, input int rb, input bit iv, input int ir);
        rst                  = r;
        bus.ctrl_writeEnable = we;
        bus.ctrl_writeReg    = 5'(wr);
        bus.data_writeReg    = wd;
        bus.ctrl_readRegA    = 5'(ra);
        bus.ctrl_readRegB    = 5'(rb);
        bus.ctrl_issueValid  = iv;
        bus.ctrl_issueReg    = 5'(ir);
        #1;
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        if (idx == 0) return 32'h0;
        if (bus.ctrl_writeEnable && int'(bus.ctrl_writeReg) == idx) return bus.data_writeReg;
        return m_mem[idx];
    endfunction

    function automatic bit being_written(input int idx);
        return bus.ctrl_writeEnable && int'(bus.ctrl_writeReg) == idx;
    endfunction

    function automatic bit exp_stall();
        int ir;
        ir = int'(bus.ctrl_issueReg);
        return bus.ctrl_issueValid && ir != 0 && m_pend[ir] && !being_written(ir);
    endfunction

    // Compare every output of the default instance against the model.
    task automatic check_all(input string tag);
        int ra;
        int rb;
        ra = int'(bus.ctrl_readRegA);
        rb = int'(bus.ctrl_readRegB);
        check_val({tag, ".rdA"}, bus.data_readRegA, exp_read(ra));
        check_val({tag, ".rdB"}, bus.data_readRegB, exp_read(rb));
        check_val({tag, ".hzA"}, 32'(bus.hazard_A), 32'(m_pend[ra] && !being_written(ra)));
        check_val({tag, ".hzB"}, 32'(bus.hazard_B), 32'(m_pend[rb] && !being_written(rb)));
        check_val({tag, ".stall"}, 32'(bus.issue_stall), 32'(exp_stall()));
    endtask

    // Advance one clock and apply the architectural effect of the cycle.
    task automatic tick();
        bit accept;
        int wr;
        int ir;
        accept = bus.ctrl_issueValid && !exp_stall() && bus.ctrl_issueReg != 0;
        wr = int'(bus.ctrl_writeReg);
        ir = int'(bus.ctrl_issueReg);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (bus.ctrl_writeEnable && wr != 0) begin
                m_mem[wr]  = bus.data_writeReg;
                m_pend[wr] = 1'b0;
            end
            if (accept) m_pend[ir] = 1'b1;
        end
        #1;
    endtask

    task automatic drive_s(input bit r, input bit we, input int wr, input logic [15:0] wd,
                           input int ra, input int rb, input bit iv, input int ir);
        rst_s               = r;
        sb.ctrl_writeEnable = we;
        sb.ctrl_writeReg    = 3'(wr);
        sb.data_writeReg    = wd;
        sb.ctrl_readRegA    = 3'(ra);
        sb.ctrl_readRegB    = 3'(rb);
        sb.ctrl_issueValid  = iv;
        sb.ctrl_issueReg    = 3'(ir);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'hxxxx_xxxx;
            m_pend[i] = 1'b0;
        end
        drive_s(1, 0, 0, 16'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        tick();

        // Reset state across all indices
        for (int i = 0; i < 32; i += 2) begin
            drive(0, 0, 0, 32'h0, i, i + 1, 0, 0);
            check_val("rst.rdA", bus.data_readRegA, 32'h0);
            check_val("rst.rdB", bus.data_readRegB, 32'h0);
            check_val("rst.hz", 32'({bus.hazard_A, bus.hazard_B, bus.issue_stall}), 32'h0);
        end

        // r0 discards writes
        drive(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        check_val("r0.wr", bus.data_readRegA, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        check_val("r0.rd", bus.data_readRegA, 32'h0);

        // Bypass then persistence
        drive(0, 1, 5, 32'h12345678, 5, 0, 0, 0);
        check_val("byp.r5", bus.data_readRegA, 32'h12345678);
        check_all("byp");
        tick();
        drive(0, 0, 0, 32'h0, 5, 5, 0, 0);
        check_val("keep.r5", bus.data_readRegA, 32'h12345678);
        check_all("keep");

        // RAW on r7
        drive(0, 0, 0, 32'h0, 7, 0, 1, 7);
        check_all("iss7");
        tick();
        drive(0, 0, 0, 32'h0, 7, 0, 0, 0);
        check_val("raw7.hz", 32'(bus.hazard_A), 32'h1);
        tick();
        drive(0, 0, 0, 32'h0, 0, 7, 0, 0);
        check_val("raw7.hzB", 32'(bus.hazard_B), 32'h1);
        tick();
        drive(0, 1, 7, 32'hA5, 7, 0, 0, 0);
        check_val("wb7.hz", 32'(bus.hazard_A), 32'h0);
        check_val("wb7.rd", bus.data_readRegA, 32'hA5);
        tick();
        drive(0, 0, 0, 32'h0, 7, 0, 0, 0);
        check_val("clr7.hz", 32'(bus.hazard_A), 32'h0);
        check_all("clr7");

        // WAW on r9
        drive(0, 0, 0, 32'h0, 9, 0, 1, 9);
        check_val("iss9.stall", 32'(bus.issue_stall), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 9, 0, 1, 9);
        check_val("waw9.stall", 32'(bus.issue_stall), 32'h1);
        tick();
        drive(0, 1, 9, 32'h99, 9, 0, 1, 9);
        check_val("retry9.stall", 32'(bus.issue_stall), 32'h0);
        check_all("retry9");
        tick();
        drive(0, 0, 0, 32'h0, 9, 0, 0, 0);
        check_val("retry9.pend", 32'(bus.hazard_A), 32'h1);
        check_val("retry9.data", bus.data_readRegA, 32'h99);
        // Issue to r0 never stalls
        drive(0, 0, 0, 32'h0, 0, 0, 1, 0);
        check_val("iss0.stall", 32'(bus.issue_stall), 32'h0);
        tick();

        // Reset drops outstanding r3
        drive(0, 0, 0, 32'h0, 3, 0, 1, 3);
        tick();
        drive(1, 0, 0, 32'h0, 3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 32'h0, 3, 9, 0, 0);
        check_val("rst3.hz", 32'(bus.hazard_A), 32'h0);
        check_val("rst9.hz", 32'(bus.hazard_B), 32'h0);
        check_val("rst9.rd", bus.data_readRegB, 32'h0);
        drive(0, 1, 3, 32'h55, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 32'h0, 3, 0, 0, 0);
        check_val("rst3.rd", bus.data_readRegA, 32'h55);

        // Random traffic concentrated on a few registers
        for (int n = 0; n < 400; n++) begin
            int wr;
            int ra;
            int rb;
            int ir;
            wr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            ra = int'($urandom_range(0, 7));
            rb = int'($urandom_range(0, 31));
            ir = int'($urandom_range(0, 6));
            drive(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, wr, $urandom,
                  ra, rb, $urandom_range(0, 1) == 1, ir);
            check_all("rnd");
            tick();
        end
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);

        // Narrow configuration
        drive_s(0, 1, 7, 16'hFFFF, 7, 0, 0, 0);
        check_val("s.byp7", 32'(sb.data_readRegA), 32'hFFFF);
        @(posedge clk);
        #1;
        drive_s(0, 1, 0, 16'h1234, 7, 0, 1, 3);
        check_val("s.rd7", 32'(sb.data_readRegA), 32'hFFFF);
        check_val("s.rd0", 32'(sb.data_readRegB), 32'h0);
        @(posedge clk);
        #1;
        drive_s(0, 0, 0, 16'h0, 0, 3, 1, 3);
        check_val("s.r0", 32'(sb.data_readRegA), 32'h0);
        check_val("s.hz3", 32'(sb.hazard_B), 32'h1);
        check_val("s.stall3", 32'(sb.issue_stall), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_scoreboard
`default_nettype wire
